ahb_master: RTL and testbench
=============================

// Module: ahb_master
// PURPOSE
//  Single-master AHB initiator; bus-side counterpart of ahb_slave. Turns a simple
//  command/data-stream interface into pipelined AHB transfers (SINGLE or INCR bursts).
//  Sits between test/control logic and the ahb_slave ports. No arbitration
//  (hbusreq/hgrant absent); address decode (hselx) lives outside this block.
// PARAMETERS
//  addrWidth  8   haddr / cmd_addr width
//  dataWidth  32  hwdata/hrdata width; hsize fixed at log2(dataWidth/8)
// PORTS
//  hclk         in   1          bus clock, single clock domain
//  hresetn      in   1          asynchronous, active-low reset
//  cmd_valid    in   1          command request
//  cmd_ready    out  1          command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1          1 = write burst, 0 = read burst
//  cmd_addr     in   addrWidth  start address, size-aligned
//  cmd_len      in   4          beats-1 (0 = SINGLE, 1..15 = INCR of 2..16 beats)
//  wdata_valid  in   1          write data available
//  wdata_ready  out  1          write beat consumed this cycle
//  wdata        in   dataWidth  write beat data
//  rdata_valid  out  1          one-cycle pulse per completed OKAY read beat
//  rdata        out  dataWidth  read beat data, valid with rdata_valid
//  done         out  1          one-cycle pulse: command finished
//  done_err     out  1          qualifies done: command aborted by a non-OKAY response
//  htrans       out  2          IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  haddr        out  addrWidth  transfer address
//  hwrite       out  1          transfer direction
//  hsize        out  3          constant log2(dataWidth/8)
//  hburst       out  3          000 SINGLE when cmd_len=0, else 001 INCR
//  hwdata       out  dataWidth  write data, driven in data phase
//  hready       in   1          slave ready; ends the current data phase
//  hresp        in   2          00 OKAY, 01 ERROR; 10 RETRY and 11 SPLIT handled as ERROR
//  hrdata       in   dataWidth  read data
// BEHAVIOUR
//  - Reset: htrans=IDLE, haddr=0, hwrite=0, hburst=0, hwdata=0, rdata=0; rdata_valid,
//    done, done_err, wdata_ready = 0; FSM=IDLE, so cmd_ready=1.
//  - All AHB outputs are registered. cmd_ready = (state==IDLE).
//  - FSM: IDLE -> ADDR on command accept. ADDR: address phases outstanding.
//    ADDR -> LAST after the final beat's address phase is accepted.
//    LAST: final data phase with htrans=IDLE. LAST -> IDLE when hready=1 (pulse done).
//    ADDR/LAST -> ERR on first-cycle error. ERR -> IDLE on the following hready=1
//    (pulse done + done_err).
//  - Pipelining: an address phase is accepted on a rising edge with hready=1.
//    The next beat's address phase overlaps the previous beat's data phase.
//    While hready=0, htrans/haddr/hwrite/hburst/hwdata are held stable.
//  - First beat is NONSEQ, later beats SEQ. haddr += dataWidth/8 per beat, modulo
//    2^addrWidth. Commands crossing a 1KB boundary are illegal (caller's responsibility).
//  - Write flow control: a write beat is issued only when wdata_valid=1.
//    - wdata_ready pulses in the same cycle; data goes to a pending register and is
//      copied to hwdata when that address phase is accepted.
//    - No wdata_valid at the first beat: htrans stays IDLE. Mid-burst: drive BUSY,
//      with haddr holding the next beat's address.
//    - Reads never stall; a read burst is issued back-to-back.
//  - Read data: rdata_valid=1 and rdata<=hrdata for each data phase ending with
//    hready=1, hwrite=0 and hresp=OKAY.
//  - Error (hready=0, hresp!=OKAY): htrans<=IDLE on that edge, cancelling any presented
//    beat and all remaining beats. No retry. Read data from the error beat is dropped.
//  - LAST and back-to-back commands: a new command is accepted only in IDLE, so there
//    is at least one IDLE bus cycle between commands.
//  - Reset mid-burst: all outputs return to reset values immediately; done is not pulsed
//    for the aborted command.
// TESTING
//  - Single write: addr=0x10, len=0, wdata=0xDEADBEEF, hready=1 ->
//    NONSEQ/SINGLE at 0x10, hwdata=0xDEADBEEF next cycle, done at 3rd cycle, done_err=0.
//  - 4-beat read from 0x20, hready low 2 cycles on beat 2 ->
//    haddr 0x20,24,28,2C with SEQ held during wait, 4 rdata_valid pulses in order.
//  - Write burst len=3, wdata_valid dropped 2 cycles after beat 1 -> BUSY 2 cycles at
//    haddr=0x04, then SEQ resumes; hwdata order intact.
//  - Read burst len=7, ERROR on beat 3 -> htrans=IDLE in the error cycle, no further
//    address phases, 2 rdata_valid pulses, done+done_err=1.
//  - hresetn low during beat 2 of an 8-beat write -> htrans=IDLE asynchronously,
//    cmd_ready=1 after release, no done pulse.
//  - Address wrap: read len=3 at 0xF8 (addrWidth=8) -> haddr 0xF8,0xFC,0x00,0x04.

Source files
------------

// File: rtl/ahb_master_if.sv
// AHB bus signals between the ahb_master initiator and a slave.
interface ahb_master_if #(
  parameter int unsigned addrWidth = 8,
  parameter int unsigned dataWidth = 32
);
  logic [1:0]           htrans;
  logic [addrWidth-1:0] haddr;
  logic                 hwrite;
  logic [2:0]           hsize;
  logic [2:0]           hburst;
  logic [dataWidth-1:0] hwdata;
  logic                 hready;
  logic [1:0]           hresp;
  logic [dataWidth-1:0] hrdata;

  modport master (output htrans, haddr, hwrite, hsize, hburst, hwdata,
                  input  hready, hresp, hrdata);
  modport slave  (input  htrans, haddr, hwrite, hsize, hburst, hwdata,
                  output hready, hresp, hrdata);
endinterface

// File: rtl/ahb_master.sv
// Single-master AHB initiator: turns a command/write-stream interface into
// pipelined SINGLE/INCR transfers, returning read beats and a completion pulse.
module ahb_master #(
  parameter int unsigned addrWidth = 8,
  parameter int unsigned dataWidth = 32
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [3:0]           cmd_len,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  input  logic [dataWidth-1:0] wdata,
  output logic                 rdata_valid,
  output logic [dataWidth-1:0] rdata,
  output logic                 done,
  output logic                 done_err,
  ahb_master_if.master         bus
);
  localparam int unsigned          BYTES = dataWidth / 8;
  localparam logic [2:0]           HSIZE = 3'($clog2(BYTES));
  localparam logic [addrWidth-1:0] STEP  = addrWidth'(BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic [1:0]           state, state_d;
  logic [4:0]           rem, rem_d;
  logic [addrWidth-1:0] nxt_addr, nxt_addr_d;
  logic                 wr, wr_d;
  logic                 started, started_d;
  logic [dataWidth-1:0] wpend, wpend_d;
  logic                 dp_act, dp_act_d;
  logic                 dp_rd, dp_rd_d;
  logic [1:0]           htrans, htrans_d;
  logic [addrWidth-1:0] haddr, haddr_d;
  logic                 hwrite, hwrite_d;
  logic [2:0]           hburst, hburst_d;
  logic [dataWidth-1:0] hwdata, hwdata_d;
  logic [dataWidth-1:0] rdata_d;
  logic                 rdata_valid_d, done_d, done_err_d;
  logic                 err;

  assign cmd_ready   = (state == S_IDLE);
  assign err         = dp_act && !bus.hready && (bus.hresp != 2'b00);
  assign bus.htrans  = htrans;
  assign bus.haddr   = haddr;
  assign bus.hwrite  = hwrite;
  assign bus.hsize   = HSIZE;
  assign bus.hburst  = hburst;
  assign bus.hwdata  = hwdata;

  // Next-state and registered-output logic; AHB outputs only move on hready edges.
  always_comb begin
    state_d       = state;
    rem_d         = rem;
    nxt_addr_d    = nxt_addr;
    wr_d          = wr;
    started_d     = started;
    wpend_d       = wpend;
    dp_act_d      = dp_act;
    dp_rd_d       = dp_rd;
    htrans_d      = htrans;
    haddr_d       = haddr;
    hwrite_d      = hwrite;
    hburst_d      = hburst;
    hwdata_d      = hwdata;
    rdata_d       = rdata;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    done_err_d    = 1'b0;
    wdata_ready   = 1'b0;

    if (state == S_IDLE && cmd_valid) begin
      state_d    = S_ADDR;
      rem_d      = 5'(cmd_len) + 5'd1;
      nxt_addr_d = cmd_addr;
      wr_d       = cmd_write;
      started_d  = 1'b0;
      hburst_d   = (cmd_len == 4'd0) ? 3'b000 : 3'b001;
    end

    unique case (state)
      S_IDLE, S_ADDR: begin
        if (err) begin
          state_d  = S_ERR;
          htrans_d = T_IDLE;
          rem_d    = 5'd0;
        end else if (bus.hready && state_d == S_ADDR) begin
          dp_act_d = htrans[1];
          dp_rd_d  = !hwrite;
          if (htrans[1] && hwrite) hwdata_d = wpend;
          if (dp_act && dp_rd && bus.hresp == 2'b00) begin
            rdata_valid_d = 1'b1;
            rdata_d       = bus.hrdata;
          end
          if (rem_d != 5'd0) begin
            hwrite_d = wr_d;
            haddr_d  = nxt_addr_d;
            if (!wr_d || wdata_valid) begin
              wdata_ready = wr_d;
              htrans_d    = started_d ? T_SEQ : T_NONSEQ;
              if (wr_d) wpend_d = wdata;
              nxt_addr_d  = nxt_addr_d + STEP;
              rem_d       = rem_d - 5'd1;
              started_d   = 1'b1;
            end else begin
              // write stream stalled: BUSY mid-burst, nothing before the first beat
              htrans_d = started_d ? T_BUSY : T_IDLE;
            end
          end else begin
            htrans_d = T_IDLE;
            state_d  = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (err) begin
          state_d = S_ERR;
        end else if (bus.hready) begin
          if (dp_rd && bus.hresp == 2'b00) begin
            rdata_valid_d = 1'b1;
            rdata_d       = bus.hrdata;
          end
          dp_act_d = 1'b0;
          state_d  = S_IDLE;
          done_d   = 1'b1;
        end
      end
      S_ERR: begin
        if (bus.hready) begin
          dp_act_d   = 1'b0;
          state_d    = S_IDLE;
          done_d     = 1'b1;
          done_err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= S_IDLE;
      rem         <= 5'd0;
      nxt_addr    <= '0;
      wr          <= 1'b0;
      started     <= 1'b0;
      wpend       <= '0;
      dp_act      <= 1'b0;
      dp_rd       <= 1'b0;
      htrans      <= T_IDLE;
      haddr       <= '0;
      hwrite      <= 1'b0;
      hburst      <= 3'b000;
      hwdata      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      done_err    <= 1'b0;
    end else begin
      state       <= state_d;
      rem         <= rem_d;
      nxt_addr    <= nxt_addr_d;
      wr          <= wr_d;
      started     <= started_d;
      wpend       <= wpend_d;
      dp_act      <= dp_act_d;
      dp_rd       <= dp_rd_d;
      htrans      <= htrans_d;
      haddr       <= haddr_d;
      hwrite      <= hwrite_d;
      hburst      <= hburst_d;
      hwdata      <= hwdata_d;
      rdata       <= rdata_d;
      rdata_valid <= rdata_valid_d;
      done        <= done_d;
      done_err    <= done_err_d;
    end
  end
endmodule

// File: tb/tb_ahb_master.sv
// Randomized bench for ahb_master: a reactive slave plus a per-command model of
// the expected beat addresses, write data order, read returns and completion.
module tb_ahb_master;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata, rdata;
  logic        rdata_valid, done, done_err;
  int          n_checks = 0;
  int          n_pass   = 0;

  ahb_master_if #(.addrWidth(8), .dataWidth(32)) bus ();

  ahb_master #(.addrWidth(8), .dataWidth(32)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .done_err(done_err),
    .bus(bus)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
  endtask

  // One command against the reactive slave; err_beat < 0 means no error.
  task automatic run_cmd(input bit wr, input logic [7:0] a0, input logic [3:0] len,
                         input int err_beat, input int wait_max);
    logic [31:0] wd [16];
    logic [31:0] rd [16];
    logic [31:0] rq [$];
    int          nb, lim, acc, nw, nrd, dp_beat, wcnt, cyc;
    bit          exp_err, errph, finished, first, p_hold, p_err;
    logic [1:0]  p_tr, ecode;
    logic [7:0]  p_ad, ea;
    logic        p_wr;
    logic [2:0]  p_hb;
    logic [31:0] p_wd;
    nb = int'(len) + 1;
    exp_err = (err_beat >= 0) && (err_beat < nb);
    lim = exp_err ? err_beat + 1 : nb;
    acc = 0; nw = 0; nrd = 0; dp_beat = -1; wcnt = 0; cyc = 0;
    errph = 0; finished = 0; first = 1; p_hold = 0; p_err = 0;
    p_tr = T_IDLE; p_ad = '0; p_wr = 1'b0; p_hb = '0; p_wd = '0;
    ecode = 2'($urandom_range(3, 1));
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      rd[i] = $urandom;
    end
    while (!finished && cyc < 600) begin
      @(negedge hclk);
      cyc++;
      if (p_err) chk("err_htrans_idle", 32'(bus.htrans), 32'(T_IDLE));
      else if (p_hold) begin
        chk("hold_htrans", 32'(bus.htrans), 32'(p_tr));
        chk("hold_haddr", 32'(bus.haddr), 32'(p_ad));
        chk("hold_hwrite", 32'(bus.hwrite), 32'(p_wr));
        chk("hold_hburst", 32'(bus.hburst), 32'(p_hb));
        chk("hold_hwdata", bus.hwdata, p_wd);
      end
      if (bus.htrans == T_BUSY) begin
        ea = 8'(int'(a0) + acc * 4);
        chk("busy_haddr", 32'(bus.haddr), 32'(ea));
        chk("busy_midburst", 32'(wr && acc > 0 && acc < nb), 32'd1);
      end
      if (rdata_valid) begin
        if (rq.size() == 0) chk("rdata_spurious", 32'(rdata_valid), 32'd0);
        else chk("rdata", rdata, rq.pop_front());
        nrd++;
      end
      if (done) begin
        chk("done_err", 32'(done_err), 32'(exp_err));
        chk("addr_phases", 32'(acc), 32'(lim));
        chk("read_beats", 32'(nrd), 32'(wr ? 0 : (exp_err ? err_beat : nb)));
        if (!exp_err) chk("write_words", 32'(nw), 32'(wr ? nb : 0));
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
        finished = 1;
      end
      bus.hrdata = $urandom;
      bus.hresp  = 2'b00;
      bus.hready = 1'b1;
      if (dp_beat >= 0) begin
        if (errph) bus.hresp = ecode;
        else if (dp_beat == err_beat) begin
          bus.hready = 1'b0;
          bus.hresp  = ecode;
        end else if (wcnt > 0) begin
          bus.hready = 1'b0;
          wcnt--;
        end else bus.hrdata = rd[dp_beat];
      end
      cmd_valid   = first && !finished;
      cmd_write   = wr;
      cmd_addr    = a0;
      cmd_len     = len;
      wdata_valid = wr && !finished && (nw < nb) && ($urandom_range(3, 0) != 0);
      wdata       = (nw < nb) ? wd[nw] : $urandom;
      #1;
      if (first) chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      first = 0;
      if (wdata_ready) begin
        chk("wdata_ready_legal", 32'(wdata_valid && wr && nw < nb), 32'd1);
        nw++;
      end
      if (dp_beat >= 0 && bus.hready) begin
        if (bus.hresp == 2'b00) begin
          if (wr) chk("hwdata", bus.hwdata, wd[dp_beat]);
          else rq.push_back(rd[dp_beat]);
        end
        dp_beat = -1;
        errph   = 0;
      end else if (dp_beat >= 0 && bus.hresp != 2'b00) errph = 1;
      p_err  = !bus.hready && (bus.hresp != 2'b00);
      p_hold = !bus.hready && !p_err;
      p_tr = bus.htrans; p_ad = bus.haddr; p_wr = bus.hwrite; p_hb = bus.hburst; p_wd = bus.hwdata;
      if (bus.hready && bus.htrans[1]) begin
        ea = 8'(int'(a0) + acc * 4);
        chk("haddr", 32'(bus.haddr), 32'(ea));
        chk("htrans", 32'(bus.htrans), 32'(acc == 0 ? T_NONSEQ : T_SEQ));
        chk("hwrite", 32'(bus.hwrite), 32'(wr));
        chk("hburst", 32'(bus.hburst), 32'(len == 4'd0 ? 3'b000 : 3'b001));
        chk("hsize", 32'(bus.hsize), 32'd2);
        dp_beat = (acc < 16) ? acc : 15;
        wcnt    = $urandom_range(wait_max, 0);
        acc++;
      end
    end
    cmd_valid   = 1'b0;
    wdata_valid = 1'b0;
    bus.hready  = 1'b1;
    bus.hresp   = 2'b00;
    if (!finished) begin
      chk("done_timeout", 32'(finished), 32'd1);
      do_reset();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    logic [3:0] rl;
    int         eb;
    hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    bus.hready = 1'b1; bus.hresp = 2'b00; bus.hrdata = '0;
    repeat (2) @(negedge hclk);
    chk("rst_htrans", 32'(bus.htrans), 32'(T_IDLE));
    chk("rst_haddr", 32'(bus.haddr), 32'd0);
    chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
    chk("rst_hburst", 32'(bus.hburst), 32'd0);
    chk("rst_hwdata", bus.hwdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {28'd0, rdata_valid, done, done_err, wdata_ready}, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    hresetn = 1'b1;
    @(negedge hclk);

    // single write, exact cycle timing
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_len = 4'd0;
    wdata_valid = 1'b1; wdata = 32'hDEADBEEF;
    #1 chk("sw_wdata_ready", 32'(wdata_ready), 32'd1);
    @(negedge hclk);
    cmd_valid = 1'b0; wdata_valid = 1'b0;
    chk("sw_nonseq", 32'(bus.htrans), 32'(T_NONSEQ));
    chk("sw_haddr", 32'(bus.haddr), 32'h10);
    chk("sw_hburst", 32'(bus.hburst), 32'd0);
    chk("sw_hwrite", 32'(bus.hwrite), 32'd1);
    @(negedge hclk);
    chk("sw_hwdata", bus.hwdata, 32'hDEADBEEF);
    chk("sw_idle", 32'(bus.htrans), 32'(T_IDLE));
    chk("sw_no_done", 32'(done), 32'd0);
    @(negedge hclk);
    chk("sw_done", 32'(done), 32'd1);
    chk("sw_done_err", 32'(done_err), 32'd0);
    @(negedge hclk);
    chk("sw_done_pulse", 32'(done), 32'd0);

    run_cmd(1'b0, 8'h20, 4'd3, -1, 2);
    run_cmd(1'b1, 8'h00, 4'd3, -1, 0);
    run_cmd(1'b0, 8'h40, 4'd7, 2, 1);
    run_cmd(1'b0, 8'hF8, 4'd3, -1, 0);
    run_cmd(1'b1, 8'hF0, 4'd7, 5, 1);

    // reset while beat 2 of an 8-beat write is on the bus
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h80; cmd_len = 4'd7;
    wdata_valid = 1'b1; wdata = $urandom;
    @(negedge hclk);
    cmd_valid = 1'b0;
    @(negedge hclk);
    chk("mr_busy_bus", 32'(bus.htrans), 32'(T_SEQ));
    #1 hresetn = 1'b0;
    #1;
    chk("mr_htrans", 32'(bus.htrans), 32'(T_IDLE));
    chk("mr_haddr", 32'(bus.haddr), 32'd0);
    chk("mr_hwdata", bus.hwdata, 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    wdata_valid = 1'b0;
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("mr_no_done", 32'(done), 32'd0);
      chk("mr_idle", 32'(bus.htrans), 32'(T_IDLE));
      chk("mr_ready", 32'(cmd_ready), 32'd1);
    end

    for (int n = 0; n < 40; n++) begin
      rl = 4'($urandom);
      eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(int'(rl), 0)) : -1;
      run_cmd(1'($urandom), 8'($urandom) & 8'hFC, rl, eb, int'($urandom_range(2, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
